tcm_sram: RTL and testbench

- Parametrised, synthesisable-style single-port TCM SRAM with a valid/ready command and response interface, for use as ITCM or DTCM.
- Adds the following over the plain simulation RAM:
  - response backpressure with held read data
  - out-of-range address detection
  - a hardware clear engine that fills memory with a constant
- Sits between the core LSU/IFU and the memory array; ITCM and DTCM are instances with different parameters.

---
 rtl/tcm_sram_pkg.sv | 27 ++
 rtl/tcm_sram_if.sv | 27 ++
 rtl/tcm_sram_clr_fsm.sv | 71 +++++++
 rtl/tcm_sram.sv | 104 ++++++++++
 tb/tb_tcm_sram.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcm_sram_pkg.sv
// Shared types, constants and helpers for the tightly-coupled memory.
// Holds clear-FSM state encodings, clog2, and default ITCM/DTCM geometry.
package tcm_sram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int ITCM_DP = 4096;
    localparam int ITCM_DW = 64;
    localparam int DTCM_DP = 2048;
    localparam int DTCM_DW = 32;

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) bits++;
        return bits;
    endfunction

    // Index width for a DP-deep array; never collapses to zero bits.
    function automatic int idx_bits(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/tcm_sram_if.sv
// Command/response bus of the TCM: valid/ready command, valid/ready read response.
interface tcm_sram_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MW = DW / 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [MW-1:0] cmd_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/tcm_sram_clr_fsm.sv
// Clear engine: walks word addresses 0..DP-1 once per clr_req, one word per cycle,
// and pulses clr_done on the return to IDLE.
module tcm_sram_clr_fsm
    import tcm_sram_pkg::*;
#(
    parameter int DP = 512,
    parameter int IW = idx_bits(DP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          clr_we,
    output logic [IW-1:0] clr_addr,
    output logic          idle
);

    state_t        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          done_d;
    logic          last;

    assign last = (cnt_q == IW'(DP - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value; the combinational block below uses blocking ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            clr_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clr_done <= done_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        clr_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (last) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    assign clr_addr = cnt_q;
    assign clr_busy = (state_q == ST_CLEAR);
    assign idle     = (state_q == ST_IDLE);

endmodule

// File: rtl/tcm_sram.sv
// Single-port TCM SRAM with valid/ready command/response, range checking and clear engine.
// Optional TCM_SRAM_INITFILE_EN adds the INIT_FILE parameter.
module tcm_sram
    import tcm_sram_pkg::*;
#(
    parameter int            DP           = 512,
    parameter int            DW           = 32,
    parameter int            MW           = DW / 8,
    parameter int            AW           = 32,
    parameter logic [DW-1:0] CLR_VAL      = '0,
    parameter bit            FORCE_X2ZERO = 1'b0
`ifdef TCM_SRAM_INITFILE_EN
    ,
    parameter string         INIT_FILE    = ""
`endif
) (
    input  logic        clk,
    input  logic        rst,
    tcm_sram_if.slave   bus,
    input  logic        clr_req,
    output logic        clr_busy,
    output logic        clr_done
);

    localparam int IW = idx_bits(DP);

    logic [DW-1:0] mem [DP];

    logic          idle;
    logic          clr_we;
    logic [IW-1:0] clr_addr;
    logic          cmd_ready;
    logic          fire;
    logic          in_range;
    logic [IW-1:0] idx;
    logic          wr_en;
    logic          rd_en;
    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic [DW-1:0] rdata_q;

    tcm_sram_clr_fsm #(
        .DP (DP),
        .IW (IW)
    ) u_clr_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .idle     (idle)
    );

    // Full-width compare keeps non-power-of-two depths from aliasing.
    assign in_range  = (bus.cmd_addr < AW'(DP));
    assign idx       = bus.cmd_addr[IW-1:0];
    assign cmd_ready = idle & ~clr_req & (~rsp_valid_q | bus.rsp_ready);
    assign fire      = bus.cmd_valid & cmd_ready;
    assign wr_en     = fire & bus.cmd_we & in_range;
    assign rd_en     = fire & ~bus.cmd_we;

    // NOTE: the array has no reset; clearing it is the clear engine's job,
    // which keeps it mappable onto SRAM macros.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= CLR_VAL;
        end else if (wr_en) begin
            for (int i = 0; i < MW; i++) begin
                if (bus.cmd_wmask[i]) mem[idx][8*i +: 8] <= bus.cmd_wdata[8*i +: 8];
            end
        end
    end

    // Response registers only load on an accepted read, so they hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
        end else if (rd_en) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ~in_range;
            rdata_q     <= in_range ? mem[idx] : '0;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;

    // Only 1'b1 survives the case-equality, so X/Z bits read back as 0 in simulation.
    if (FORCE_X2ZERO) begin : g_x2zero
        for (genvar i = 0; i < DW; i++) begin : g_bit
            assign bus.rsp_rdata[i] = (rdata_q[i] === 1'b1);
        end
    end else begin : g_pass
        assign bus.rsp_rdata = rdata_q;
    end

endmodule

// File: tb/tb_tcm_sram.sv
// Self-checking bench for tcm_sram: a 512-word and a 500-word instance checked
// against an array-based reference model with randomized traffic.
module tb_tcm_sram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wmask = '0;
    logic        rsp_ready = 1'b0;
    logic        clr_req = 1'b0;

    logic        busy0, done0, busy1, done1;
    logic        obs_ready, obs_valid, obs_err, obs_busy, obs_done;
    logic [31:0] obs_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [2][512];
    bit          known [2][512];
    int          depth [2] = '{512, 500};

    always #5 clk = ~clk;

    tcm_sram_if #(.AW(32), .DW(32)) bus0 ();
    tcm_sram_if #(.AW(32), .DW(32)) bus1 ();

    assign bus0.cmd_valid = cmd_valid & ~sel;
    assign bus1.cmd_valid = cmd_valid & sel;
    assign bus0.rsp_ready = rsp_ready & ~sel;
    assign bus1.rsp_ready = rsp_ready & sel;
    assign bus0.cmd_we    = cmd_we;
    assign bus1.cmd_we    = cmd_we;
    assign bus0.cmd_addr  = cmd_addr;
    assign bus1.cmd_addr  = cmd_addr;
    assign bus0.cmd_wdata = cmd_wdata;
    assign bus1.cmd_wdata = cmd_wdata;
    assign bus0.cmd_wmask = cmd_wmask;
    assign bus1.cmd_wmask = cmd_wmask;

    assign obs_ready = sel ? bus1.cmd_ready : bus0.cmd_ready;
    assign obs_valid = sel ? bus1.rsp_valid : bus0.rsp_valid;
    assign obs_data  = sel ? bus1.rsp_rdata : bus0.rsp_rdata;
    assign obs_err   = sel ? bus1.rsp_err   : bus0.rsp_err;
    assign obs_busy  = sel ? busy1 : busy0;
    assign obs_done  = sel ? done1 : done0;

    tcm_sram #(.DP(512), .DW(32), .AW(32), .CLR_VAL(32'h0), .FORCE_X2ZERO(1'b1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .clr_req(clr_req & ~sel),
        .clr_busy(busy0), .clr_done(done0)
    );

    tcm_sram #(.DP(500), .DW(32), .AW(32), .CLR_VAL(32'h0), .FORCE_X2ZERO(1'b0)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .clr_req(clr_req & sel),
        .clr_busy(busy1), .clr_done(done1)
    );

    // Reference model: byte-granular write into a plain array, range-checked by depth.
    function automatic void model_write(input int s, input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] m);
        if (a < 32'(depth[s])) begin
            for (int b = 0; b < 4; b++) if (m[b]) model[s][a][8*b +: 8] = d[8*b +: 8];
            if (m == 4'hF) known[s][a] = 1'b1;
        end
    endfunction

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] mask);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = data; cmd_wmask = mask;
        @(negedge clk);
        while (obs_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout addr=%0h ready=%b required 1", addr, obs_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (we) model_write(int'(sel), addr, data, mask);
    endtask

    // Issues a read, checks the response one cycle later, then consumes it.
    task automatic do_read(input string name, input logic [31:0] addr);
        logic [31:0] exp_d;
        logic        exp_e;
        bit          exp_known;
        exp_e     = (addr >= 32'(depth[int'(sel)]));
        exp_d     = exp_e ? 32'h0 : model[int'(sel)][addr[8:0]];
        exp_known = exp_e || known[int'(sel)][addr[8:0]];
        send(1'b0, addr, 32'h0, 4'h0);
        @(negedge clk);
        checks++;
        if (obs_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid addr=%0d got %b expected 1", name, addr, obs_valid);
        end
        checks++;
        if (obs_err !== exp_e) begin
            errors++;
            $display("FAIL %s_err addr=%0d got %b expected %b", name, addr, obs_err, exp_e);
        end
        if (exp_known) begin
            checks++;
            if (obs_data !== exp_d) begin
                errors++;
                $display("FAIL %s_data addr=%0d got %h expected %h", name, addr, obs_data, exp_d);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({obs_valid, obs_err, obs_busy, obs_done} !== 4'b0000 || obs_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b e=%b b=%b d=%b data=%h expected all 0",
                     obs_valid, obs_err, obs_busy, obs_done, obs_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b expected 1", obs_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        send(1'b1, 32'd5, 32'hDEADBEEF, 4'hF);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'd5;
        @(negedge clk);
        checks++;
        if (obs_ready !== 1'b1 || obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_rd_pre got ready=%b valid=%b expected 1/0", obs_ready, obs_valid);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_valid !== 1'b1 || obs_data !== 32'hDEADBEEF || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_rd_rsp got v=%b data=%h e=%b expected 1/deadbeef/0",
                     obs_valid, obs_data, obs_err);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_rd_drop got valid=%b expected 0", obs_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mask();
        send(1'b1, 32'd5, 32'h11223344, 4'b0101);
        checks++;
        if (model[0][5] !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL mask_model got %h expected de22be44", model[0][5]);
        end
        do_read("mask_0101", 32'd5);
        send(1'b1, 32'd5, $urandom, 4'b0000);
        do_read("mask_none", 32'd5);
    endtask

    task automatic test_backpressure();
        logic [31:0] v;
        v = $urandom;
        send(1'b1, 32'd7, v, 4'hF);
        send(1'b0, 32'd7, 32'h0, 4'h0);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs_ready !== 1'b0 || obs_valid !== 1'b1 || obs_data !== v) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got ready=%b v=%b data=%h expected 0/1/%h",
                         i, obs_ready, obs_valid, obs_data, v);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready got %b expected 1", obs_ready);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_valid !== 1'b1 || obs_data !== model[0][5]) begin
            errors++;
            $display("FAIL bp_next got v=%b data=%h expected 1/%h", obs_valid, obs_data, model[0][5]);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [$];
        logic [31:0] a;
        for (int i = 16; i < 24; i++) send(1'b1, 32'(i), $urandom, 4'hF);
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = 32'($urandom_range(16, 23));
            cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = a;
            @(negedge clk);
            checks++;
            if (obs_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready i=%0d got %b expected 1", i, obs_ready);
            end
            if (i > 0) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL b2b_rsp i=%0d got v=%b data=%h expected 1/%h",
                             i, obs_valid, obs_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            exp_q.push_back(model[0][a]);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_valid !== 1'b1 || obs_data !== exp_q[0]) begin
            errors++;
            $display("FAIL b2b_last got v=%b data=%h expected 1/%h", obs_valid, obs_data, exp_q[0]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got valid=%b expected 0", obs_valid);
        end
        rsp_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 9) == 0) ? 32'(512 + $urandom_range(0, 15))
                                            : 32'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) send(1'b1, a, $urandom, 4'($urandom));
            else do_read("rand", a);
        end
    endtask

    task automatic test_out_of_range();
        sel = 1'b1;
        send(1'b1, 32'd0,    32'hA0A0A0A0, 4'hF);
        send(1'b1, 32'd488,  32'hB1B1B1B1, 4'hF);
        send(1'b1, 32'd499,  32'hC2C2C2C2, 4'hF);
        send(1'b1, 32'd500,  32'hDEAD0500, 4'hF);
        send(1'b1, 32'd512,  32'hDEAD0512, 4'hF);
        send(1'b1, 32'd1000, 32'hDEAD1000, 4'hF);
        do_read("oor_500", 32'd500);
        do_read("oor_512", 32'd512);
        do_read("oor_alias0", 32'd0);
        do_read("oor_alias488", 32'd488);
        do_read("oor_last", 32'd499);
        sel = 1'b0;
    endtask

    task automatic test_clear();
        int busy_cnt, done_cnt;
        bit ended;
        busy_cnt = 0; done_cnt = 0; ended = 1'b0;
        clr_req = 1'b1;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'd5; cmd_wdata = 32'hFFFFFFFF; cmd_wmask = 4'hF;
        @(negedge clk);
        checks++;
        if (obs_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_priority got ready=%b expected 0", obs_ready);
        end
        @(posedge clk); #1;
        clr_req = 1'b0; cmd_valid = 1'b0;
        for (int c = 0; c < 2000 && !ended; c++) begin
            @(negedge clk);
            if (obs_busy === 1'b1) busy_cnt++;
            if (obs_done === 1'b1) begin
                done_cnt++;
                checks++;
                if (obs_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL clr_done_busy got busy=%b expected 0", obs_busy);
                end
            end
            if (c == 200) begin
                checks++;
                if (obs_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL clr_ready_low got %b expected 0", obs_ready);
                end
            end
            if (c == 50) clr_req = 1'b1;
            if (c == 51) clr_req = 1'b0;
            if (c > 0 && obs_busy !== 1'b1 && obs_done !== 1'b1) ended = 1'b1;
        end
        checks++;
        if (busy_cnt != 512 || done_cnt != 1) begin
            errors++;
            $display("FAIL clr_timing got busy=%0d done=%0d expected 512/1", busy_cnt, done_cnt);
        end
        for (int i = 0; i < 512; i++) begin
            model[0][i] = 32'h0;
            known[0][i] = 1'b1;
        end
        @(posedge clk); #1;
        do_read("clr_511", 32'd511);
        do_read("clr_5", 32'd5);
        do_read("clr_0", 32'd0);
    endtask

    task automatic test_reset_during_clear();
        logic [31:0] r7;
        r7 = $urandom;
        send(1'b1, 32'd50,  $urandom | 32'h1, 4'hF);
        send(1'b1, 32'd99,  $urandom | 32'h1, 4'hF);
        send(1'b1, 32'd100, $urandom | 32'h1, 4'hF);
        send(1'b1, 32'd300, $urandom | 32'h1, 4'hF);
        send(1'b1, 32'd7,   r7, 4'hF);
        send(1'b0, 32'd7,   32'h0, 4'h0);
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        for (int j = 0; j <= 100; j++) begin
            @(negedge clk);
            if (j == 0) begin
                checks++;
                if (obs_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL rdc_start got busy=%b expected 1", obs_busy);
                end
            end
            if (j == 10) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_data !== r7) begin
                    errors++;
                    $display("FAIL rdc_pending got v=%b data=%h expected 1/%h", obs_valid, obs_data, r7);
                end
                rsp_ready = 1'b1;
            end
            if (j == 11) begin
                rsp_ready = 1'b0;
                checks++;
                if (obs_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rdc_consumed got valid=%b expected 0", obs_valid);
                end
            end
            if (j == 100) begin
                rst = 1'b1;
                #1;
                checks++;
                if (obs_busy !== 1'b0 || obs_done !== 1'b0) begin
                    errors++;
                    $display("FAIL rdc_abort got busy=%b done=%b expected 0/0", obs_busy, obs_done);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (obs_done !== 1'b0 || obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL rdc_hold got busy=%b done=%b expected 0/0", obs_busy, obs_done);
        end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) model[0][i] = 32'h0;
        @(posedge clk); #1;
        do_read("rdc_50", 32'd50);
        do_read("rdc_99", 32'd99);
        do_read("rdc_100", 32'd100);
        do_read("rdc_300", 32'd300);
    endtask

    initial begin
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 512; i++) known[s][i] = 1'b0;
        test_reset();
        test_write_read();
        test_mask();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_out_of_range();
        test_clear();
        test_reset_during_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
